// File: rtl/ct_lsu_st_wb_cmplt_sched.sv
// Store WB completion scheduler: arbitrates DA completions against a
// small WMB completion queue, with starvation forcing of WMB.
module ct_lsu_st_wb_cmplt_sched #(
  parameter int DEPTH        = 4,
  parameter int PTR_W        = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic             ctrl_st_clk,
  input  logic             cpurst_b,
  input  logic             rtu_yy_xx_flush,
  input  logic             st_da_cmplt_req,
  input  logic [6:0]       st_da_iid,
  input  logic             st_da_expt_vld,
  input  logic             st_da_spec_fail,
  input  logic             st_da_bkpta_data,
  input  logic             st_da_bkptb_data,
  input  logic             wmb_cmplt_req,
  input  logic [6:0]       wmb_iid,
  input  logic             wmb_inst_flush,
  input  logic             wmb_spec_fail,
  input  logic             wmb_bkpta_data,
  input  logic             wmb_bkptb_data,
  output logic             sched_wmb_cmplt_grnt,
  output logic             sched_st_da_stall,
  output logic             sched_wb_vld,
  output logic             sched_wb_src_wmb,
  output logic [6:0]       sched_wb_iid,
  output logic             sched_wb_expt_vld,
  output logic             sched_wb_flush,
  output logic             sched_wb_spec_fail,
  output logic             sched_wb_bkpta_data,
  output logic             sched_wb_bkptb_data,
  output logic [PTR_W:0]   sched_q_cnt
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  logic [10:0]    r_q [DEPTH];
  logic [PTR_W:0] r_wr_ptr;
  logic [PTR_W:0] r_rd_ptr;
  logic [2:0]     r_starve_cnt;

  logic        w_full;
  logic        w_empty;
  logic        w_force;
  logic        w_sel_wmb;
  logic        w_sel_da;
  logic        w_grnt;
  logic        w_deq;
  logic [10:0] w_head;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0])
                 & (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]);
  assign w_force = !w_empty & (r_starve_cnt == LIMIT);
  assign w_sel_wmb = w_force | (!st_da_cmplt_req & !w_empty);
  assign w_sel_da  = !w_force & st_da_cmplt_req;
  assign w_grnt  = wmb_cmplt_req & !w_full & !rtu_yy_xx_flush;
  assign w_deq   = w_sel_wmb & !rtu_yy_xx_flush;
  assign w_head  = r_q[r_rd_ptr[PTR_W-1:0]];

  assign sched_wmb_cmplt_grnt = w_grnt;
  assign sched_st_da_stall    = w_force & st_da_cmplt_req;
  assign sched_q_cnt          = r_wr_ptr - r_rd_ptr;

  // Payload is forced to zero whenever nothing valid is presented
  always_comb begin
    sched_wb_vld        = 1'b0;
    sched_wb_src_wmb    = 1'b0;
    sched_wb_iid        = 7'd0;
    sched_wb_expt_vld   = 1'b0;
    sched_wb_flush      = 1'b0;
    sched_wb_spec_fail  = 1'b0;
    sched_wb_bkpta_data = 1'b0;
    sched_wb_bkptb_data = 1'b0;
    if (!rtu_yy_xx_flush) begin
      unique case (1'b1)
        w_sel_wmb: begin
          sched_wb_vld        = 1'b1;
          sched_wb_src_wmb    = 1'b1;
          sched_wb_iid        = w_head[10:4];
          sched_wb_flush      = w_head[3] | w_head[2];
          sched_wb_spec_fail  = w_head[2];
          sched_wb_bkpta_data = w_head[1];
          sched_wb_bkptb_data = w_head[0];
        end
        w_sel_da: begin
          sched_wb_vld        = 1'b1;
          sched_wb_iid        = st_da_iid;
          sched_wb_expt_vld   = st_da_expt_vld;
          sched_wb_flush      = st_da_spec_fail;
          sched_wb_spec_fail  = st_da_spec_fail;
          sched_wb_bkpta_data = st_da_bkpta_data;
          sched_wb_bkptb_data = st_da_bkptb_data;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge ctrl_st_clk) begin
    if (w_grnt)
      r_q[r_wr_ptr[PTR_W-1:0]] <= {wmb_iid, wmb_inst_flush,
                                   wmb_spec_fail, wmb_bkpta_data,
                                   wmb_bkptb_data};
  end

  always_ff @(posedge ctrl_st_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (rtu_yy_xx_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_grnt)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_deq)
        r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Counts consecutive DA wins while WMB entries wait
  always_ff @(posedge ctrl_st_clk or negedge cpurst_b) begin
    if (!cpurst_b)
      r_starve_cnt <= 3'd0;
    else if (rtu_yy_xx_flush | w_empty | w_deq)
      r_starve_cnt <= 3'd0;
    else if (w_sel_da & (r_starve_cnt != LIMIT))
      r_starve_cnt <= r_starve_cnt + 3'd1;
  end

endmodule

// File: tb/tb_ct_lsu_st_wb_cmplt_sched.sv
// Scoreboard bench for ct_lsu_st_wb_cmplt_sched against a queue-based
// reference model; directed scenarios followed by random phases.
module tb_ct_lsu_st_wb_cmplt_sched;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;
  localparam int LIM   = 3;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       fl = 1'b0;
  logic       da_req = 1'b0;
  logic [6:0] da_iid = '0;
  logic       da_expt = 1'b0, da_sf = 1'b0, da_ba = 1'b0, da_bb = 1'b0;
  logic       w_req = 1'b0;
  logic [6:0] w_iid = '0;
  logic       w_if = 1'b0, w_sf = 1'b0, w_ba = 1'b0, w_bb = 1'b0;
  logic       grnt, stall, vld, src, expt, flo, sfo, bao, bbo;
  logic [6:0] iid;
  logic [PTR_W:0] qcnt;

  always #5 clk = ~clk;

  ct_lsu_st_wb_cmplt_sched #(
    .DEPTH(DEPTH), .PTR_W(PTR_W), .STARVE_LIMIT(LIM)
  ) dut (
    .ctrl_st_clk(clk), .cpurst_b(rst_b), .rtu_yy_xx_flush(fl),
    .st_da_cmplt_req(da_req), .st_da_iid(da_iid),
    .st_da_expt_vld(da_expt), .st_da_spec_fail(da_sf),
    .st_da_bkpta_data(da_ba), .st_da_bkptb_data(da_bb),
    .wmb_cmplt_req(w_req), .wmb_iid(w_iid),
    .wmb_inst_flush(w_if), .wmb_spec_fail(w_sf),
    .wmb_bkpta_data(w_ba), .wmb_bkptb_data(w_bb),
    .sched_wmb_cmplt_grnt(grnt), .sched_st_da_stall(stall),
    .sched_wb_vld(vld), .sched_wb_src_wmb(src), .sched_wb_iid(iid),
    .sched_wb_expt_vld(expt), .sched_wb_flush(flo),
    .sched_wb_spec_fail(sfo), .sched_wb_bkpta_data(bao),
    .sched_wb_bkptb_data(bbo), .sched_q_cnt(qcnt)
  );

  typedef struct packed {
    logic       vld;
    logic       src;
    logic [6:0] iid;
    logic       expt;
    logic       fl;
    logic       sf;
    logic       ba;
    logic       bb;
    logic       grnt;
    logic       stall;
    logic [2:0] qcnt;
  } out_t;

  typedef struct {
    bit [6:0] iid;
    bit fi, sf, ba, bb;
  } ent_t;

  ent_t mq[$];
  int   starve;
  out_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   wpend = 0;
  ent_t went;
  bit [6:0] wseq = 7'h40;

  // Reference model: expected outputs from current inputs, then advance
  task automatic model();
    out_t e;
    bit empty, full, force_w, selw, selda;
    e = '0;
    if (!rst_b) begin
      mq.delete();
      starve = 0;
      exp_q.push_back(e);
      return;
    end
    empty = (mq.size() == 0);
    full  = (mq.size() == DEPTH);
    force_w = !empty && (starve == LIM);
    selw  = force_w || (!da_req && !empty);
    selda = !force_w && da_req;
    e.grnt  = w_req && !full && !fl;
    e.stall = force_w && da_req;
    e.qcnt  = 3'(mq.size());
    if (!fl && selw) begin
      e.vld = 1; e.src = 1; e.iid = mq[0].iid;
      e.fl = mq[0].fi | mq[0].sf; e.sf = mq[0].sf;
      e.ba = mq[0].ba; e.bb = mq[0].bb;
    end else if (!fl && selda) begin
      e.vld = 1; e.iid = da_iid; e.expt = da_expt;
      e.fl = da_sf; e.sf = da_sf; e.ba = da_ba; e.bb = da_bb;
    end
    exp_q.push_back(e);
    if (fl) begin
      mq.delete();
      starve = 0;
    end else begin
      if (empty || selw) starve = 0;
      else if (selda && starve < LIM) starve++;
      if (selw) void'(mq.pop_front());
      if (e.grnt) begin
        mq.push_back(went);
        wpend = 0;
      end
    end
  endtask

  task automatic cycle(input bit da, input bit [10:0] dv,
                       input bit wnew, input bit [3:0] wf,
                       input bit f);
    @(posedge clk); #1;
    if (!wpend && wnew) begin
      wpend = 1;
      went.iid = wseq; wseq = wseq + 7'd1;
      {went.fi, went.sf, went.ba, went.bb} = wf;
    end
    da_req = da;
    {da_iid, da_expt, da_sf, da_ba, da_bb} = dv;
    w_req = wpend;
    w_iid = went.iid;
    {w_if, w_sf, w_ba, w_bb} = {went.fi, went.sf, went.ba, went.bb};
    fl = f;
    model();
  endtask

  task automatic set_wmb(input bit [6:0] id);
    wseq = id;
  endtask

  task automatic rst_slot(input bit r);
    @(posedge clk); #1;
    rst_b = r;
    da_req = 0; w_req = 0; fl = 0; wpend = 0;
    model();
  endtask

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      out_t e;
      e = exp_q.pop_front();
      chk("vld", 32'(vld), 32'(e.vld));
      chk("src_wmb", 32'(src), 32'(e.src));
      chk("iid", 32'(iid), 32'(e.iid));
      chk("expt", 32'(expt), 32'(e.expt));
      chk("flush", 32'(flo), 32'(e.fl));
      chk("spec_fail", 32'(sfo), 32'(e.sf));
      chk("bkpta", 32'(bao), 32'(e.ba));
      chk("bkptb", 32'(bbo), 32'(e.bb));
      chk("grnt", 32'(grnt), 32'(e.grnt));
      chk("stall", 32'(stall), 32'(e.stall));
      chk("q_cnt", 32'(qcnt), 32'(e.qcnt));
    end
  end

  initial begin
    int pda, pw, pf;
    starve = 0;
    went = '{default: 0};
    rst_slot(0); rst_slot(0); rst_slot(1);
    // single WMB completion
    set_wmb(7'h12);
    cycle(0, '0, 1, 4'h0, 0);
    cycle(0, '0, 0, 4'h0, 0);
    cycle(0, '0, 0, 4'h0, 0);
    // DA and WMB together
    set_wmb(7'h20);
    cycle(1, {7'h05, 4'b1010}, 1, 4'b0101, 0);
    cycle(0, '0, 0, 4'h0, 0);
    cycle(0, '0, 0, 4'h0, 0);
    // starvation: one entry, DA continuous
    cycle(0, '0, 1, 4'b1000, 0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 6; i++)
      cycle(1, {7'(i + 8), 4'b0001}, 0, 4'h0, 0);
    // fill queue with DA active, then forced drains
    for (int i = 0; i < 14; i++)
      cycle(1, {7'(i + 32), 4'b0100}, 1, 4'(i), 0);
    // flush with entries queued and a request pending
    cycle(1, {7'h33, 4'b0}, 1, 4'h0, 1);
    cycle(0, '0, 0, 4'h0, 0);
    cycle(0, '0, 0, 4'h0, 0);
    // wrap-around stream
    for (int i = 0; i < 11; i++)
      cycle(0, '0, 1, 4'(i), 0);
    cycle(0, '0, 0, 4'h0, 0);
    // random phases with varying pressure
    for (int p = 0; p < 6; p++) begin
      pda = (p % 3 == 0) ? 90 : (p % 3 == 1) ? 50 : 15;
      pw  = (p < 3) ? 70 : 35;
      pf  = (p == 4) ? 10 : 3;
      for (int i = 0; i < 250; i++) begin
        if (p == 3 && i == 120) begin
          rst_slot(0); rst_slot(1);
        end
        cycle($urandom_range(99) < 32'(pda), 11'($urandom),
              $urandom_range(99) < 32'(pw), 4'($urandom),
              $urandom_range(99) < 32'(pf));
      end
    end
    @(posedge clk); #1;
    da_req = 0; w_req = 0; fl = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
